// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised byte-enabled RAM:
// sequencer states and default geometry.
package mem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/mem_array_be.sv
// Word storage with one byte-enabled synchronous write port and one registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module mem_array_be
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic              wr_hit;
   logic              rd_hit;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_L);
   assign rd_hit = {1'b0, rd_addr} < DEPTH_L;
   assign wr_idx = wr_addr[IDX_W-1:0];
   assign rd_idx = rd_addr[IDX_W-1:0];

   // Storage itself is never reset; zeroing is done by the owner's init sweep.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= rd_hit ? mem_q[rd_idx] : '0;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_ram_param.sv
// Parameterised single-port RAM with self zero-initialisation after reset or clr,
// valid/ready request handshake and 1-cycle registered read responses.
//
// state  | meaning
// S_INIT | sweeping words 0..DEPTH-1 to zero, requests blocked
// S_RUN  | accepting read/write requests
module mem_ram_param
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                init_busy
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_e              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                busy_q;
   logic                ready_q;
   logic                rsp_valid_q;
   logic                accept;
   logic                wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_d;
   logic [DATA_W-1:0]   wr_data_d;
   logic [DATA_W/8-1:0] wr_be_d;

   assign accept = req_valid && ready_q;

   // clr wins over the sweep so a pulse in S_INIT restarts from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else if (clr) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_INIT;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= accept && !req_we;
      end
   end

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = req_addr;
      wr_data_d = req_wdata;
      wr_be_d   = req_be;
      if (state_q == S_INIT) begin
         wr_en_d   = 1'b1;
         wr_addr_d = cnt_q;
         wr_data_d = '0;
         wr_be_d   = '1;
      end else if (accept && req_we) begin
         wr_en_d = 1'b1;
      end
   end

   mem_array_be #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_d),
      .wr_addr (wr_addr_d),
      .wr_data (wr_data_d),
      .wr_be   (wr_be_d),
      .rd_en   (accept && !req_we),
      .rd_addr (req_addr),
      .rd_data (rsp_rdata)
   );

   assign req_ready = ready_q;
   assign init_busy = busy_q;
   assign rsp_valid = rsp_valid_q;

endmodule
